// File: rtl/phys_reg_map_table_multi.sv
// Superscalar rename map table with a ring of checkpoint columns for branch recovery.
// Lanes rename in program order inside a group; the working column is always valid.
module phys_reg_map_table_multi #(
  parameter int NUM_ARCH_REGS      = 32,
  parameter int NUM_PHYS_REGS      = 64,
  parameter int CHECKPOINT_COLUMNS = 4,
  parameter int RENAME_WIDTH       = 2,
  parameter int ROB_INDEX_W        = 6,
  localparam int AT = $clog2(NUM_ARCH_REGS),
  localparam int PT = $clog2(NUM_PHYS_REGS),
  localparam int CT = $clog2(CHECKPOINT_COLUMNS)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [AT-1:0]          src_arch_tag [RENAME_WIDTH][2],
  output logic [PT-1:0]          src_phys_tag [RENAME_WIDTH][2],
  input  logic                   rename_valid [RENAME_WIDTH],
  input  logic [AT-1:0]          rename_dest_arch_tag [RENAME_WIDTH],
  input  logic [PT-1:0]          rename_dest_phys_tag [RENAME_WIDTH],
  output logic [PT-1:0]          rename_old_phys_tag [RENAME_WIDTH],
  input  logic                   revert_valid,
  input  logic [AT-1:0]          revert_dest_arch_tag,
  input  logic [PT-1:0]          revert_safe_phys_tag,
  input  logic                   save_checkpoint_valid,
  input  logic [ROB_INDEX_W-1:0] save_checkpoint_ROB_index,
  output logic                   save_checkpoint_accepted,
  output logic [CT-1:0]          save_checkpoint_column,
  output logic                   checkpoint_full,
  output logic [CT:0]            checkpoints_in_use,
  input  logic                   restore_valid,
  input  logic                   restore_speculate_failed,
  input  logic [ROB_INDEX_W-1:0] restore_ROB_index,
  input  logic [CT-1:0]          restore_column,
  output logic                   restore_success
);

  logic [PT-1:0]                 map_q [CHECKPOINT_COLUMNS][NUM_ARCH_REGS];
  logic [ROB_INDEX_W-1:0]        rob_q [CHECKPOINT_COLUMNS];
  logic [CHECKPOINT_COLUMNS-1:0] valid_q;
  logic [CT-1:0]                 work_q;
  logic [CT-1:0]                 next_col;
  logic                          fail_req;
  logic                          rel_req;
  logic                          tag_match;
  logic                          rename_en;
  logic                          release_ok;

  // Reads come from the working column; older lanes of the same group bypass younger ones.
  always_comb begin
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      for (int k = 0; k < 2; k++) begin
        src_phys_tag[j][k] = map_q[work_q][src_arch_tag[j][k]];
        for (int i = 0; i < j; i++) begin
          if (rename_valid[i] && (rename_dest_arch_tag[i] == src_arch_tag[j][k]))
            src_phys_tag[j][k] = rename_dest_phys_tag[i];
        end
      end
      rename_old_phys_tag[j] = map_q[work_q][rename_dest_arch_tag[j]];
      for (int i = 0; i < j; i++) begin
        if (rename_valid[i] && (rename_dest_arch_tag[i] == rename_dest_arch_tag[j]))
          rename_old_phys_tag[j] = rename_dest_phys_tag[i];
      end
    end
  end

  always_comb begin
    checkpoints_in_use = '0;
    for (int c = 0; c < CHECKPOINT_COLUMNS; c++)
      checkpoints_in_use = checkpoints_in_use + (CT+1)'(valid_q[c]);
  end

  assign next_col                 = work_q + CT'(1);
  assign fail_req                 = restore_valid & restore_speculate_failed;
  assign rel_req                  = restore_valid & ~restore_speculate_failed;
  assign tag_match                = valid_q[restore_column] & (rob_q[restore_column] == restore_ROB_index);
  assign rename_en                = ~revert_valid & ~fail_req;
  assign release_ok               = rel_req & tag_match & (restore_column != work_q);
  assign checkpoint_full          = valid_q[next_col];
  assign save_checkpoint_accepted = save_checkpoint_valid & rename_en & ~checkpoint_full;
  assign save_checkpoint_column   = work_q;
  assign restore_success          = fail_req ? (~revert_valid & tag_match) : release_ok;

  // Later non-blocking writes win, so the highest renaming lane takes precedence.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        for (int i = 0; i < NUM_ARCH_REGS; i++)
          map_q[c][i] <= (c == 0) ? PT'(i) : '0;
        rob_q[c] <= '0;
      end
      valid_q <= {{(CHECKPOINT_COLUMNS-1){1'b0}}, 1'b1};
      work_q  <= '0;
    end else begin
      if (revert_valid) begin
        map_q[work_q][revert_dest_arch_tag] <= revert_safe_phys_tag;
        for (int c = 0; c < CHECKPOINT_COLUMNS; c++)
          if (CT'(c) != work_q) valid_q[c] <= 1'b0;
      end else if (fail_req) begin
        if (tag_match) begin
          work_q <= restore_column;
          for (int c = 0; c < CHECKPOINT_COLUMNS; c++)
            if (CT'(c) != restore_column) valid_q[c] <= 1'b0;
        end
      end else begin
        if (save_checkpoint_accepted) begin
          for (int i = 0; i < NUM_ARCH_REGS; i++)
            map_q[next_col][i] <= map_q[work_q][i];
          valid_q[next_col] <= 1'b1;
          rob_q[next_col]   <= save_checkpoint_ROB_index;
          rob_q[work_q]     <= save_checkpoint_ROB_index;
          work_q            <= next_col;
        end
        // Renames in the branch's group are older than it, so they land in both columns.
        for (int i = 0; i < RENAME_WIDTH; i++) begin
          if (rename_valid[i]) begin
            map_q[work_q][rename_dest_arch_tag[i]] <= rename_dest_phys_tag[i];
            if (save_checkpoint_accepted)
              map_q[next_col][rename_dest_arch_tag[i]] <= rename_dest_phys_tag[i];
          end
        end
      end
      if (release_ok) valid_q[restore_column] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phys_reg_map_table_multi.sv
// Bench for phys_reg_map_table_multi: directed scenarios then random traffic
// against a sequential column-list model of the rename table.
module tb_phys_reg_map_table_multi;
  localparam int NA = 32, NP = 64, C = 4, W = 2, RW = 6;
  localparam int AT = 5, PT = 6, CT = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [AT-1:0] src_arch_tag [W][2];
  logic [PT-1:0] src_phys_tag [W][2];
  logic          rename_valid [W];
  logic [AT-1:0] rename_dest_arch_tag [W];
  logic [PT-1:0] rename_dest_phys_tag [W];
  logic [PT-1:0] rename_old_phys_tag [W];
  logic          revert_valid;
  logic [AT-1:0] revert_dest_arch_tag;
  logic [PT-1:0] revert_safe_phys_tag;
  logic          save_checkpoint_valid;
  logic [RW-1:0] save_checkpoint_ROB_index;
  logic          save_checkpoint_accepted;
  logic [CT-1:0] save_checkpoint_column;
  logic          checkpoint_full;
  logic [CT:0]   checkpoints_in_use;
  logic          restore_valid;
  logic          restore_speculate_failed;
  logic [RW-1:0] restore_ROB_index;
  logic [CT-1:0] restore_column;
  logic          restore_success;

  phys_reg_map_table_multi #(
    .NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP), .CHECKPOINT_COLUMNS(C),
    .RENAME_WIDTH(W), .ROB_INDEX_W(RW)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .src_arch_tag(src_arch_tag), .src_phys_tag(src_phys_tag),
    .rename_valid(rename_valid), .rename_dest_arch_tag(rename_dest_arch_tag),
    .rename_dest_phys_tag(rename_dest_phys_tag), .rename_old_phys_tag(rename_old_phys_tag),
    .revert_valid(revert_valid), .revert_dest_arch_tag(revert_dest_arch_tag),
    .revert_safe_phys_tag(revert_safe_phys_tag),
    .save_checkpoint_valid(save_checkpoint_valid),
    .save_checkpoint_ROB_index(save_checkpoint_ROB_index),
    .save_checkpoint_accepted(save_checkpoint_accepted),
    .save_checkpoint_column(save_checkpoint_column),
    .checkpoint_full(checkpoint_full), .checkpoints_in_use(checkpoints_in_use),
    .restore_valid(restore_valid), .restore_speculate_failed(restore_speculate_failed),
    .restore_ROB_index(restore_ROB_index), .restore_column(restore_column),
    .restore_success(restore_success)
  );

  always #5 CLK = ~CLK;

  int m_map [C][NA];
  int m_rob [C];
  bit m_valid [C];
  int m_work;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      for (int i = 0; i < NA; i++) m_map[c][i] = (c == 0) ? i : 0;
      m_valid[c] = (c == 0);
      m_rob[c] = 0;
    end
    m_work = 0;
  endtask

  task automatic idle();
    for (int j = 0; j < W; j++) begin
      src_arch_tag[j][0] = '0; src_arch_tag[j][1] = '0;
      rename_valid[j] = 1'b0; rename_dest_arch_tag[j] = '0; rename_dest_phys_tag[j] = '0;
    end
    revert_valid = 1'b0; revert_dest_arch_tag = '0; revert_safe_phys_tag = '0;
    save_checkpoint_valid = 1'b0; save_checkpoint_ROB_index = '0;
    restore_valid = 1'b0; restore_speculate_failed = 1'b0;
    restore_ROB_index = '0; restore_column = '0;
  endtask

  // Check all outputs against the model, then advance one clock and update the model.
  task automatic step();
    int cur [NA];
    int w1, rc, idx, rarch, rsafe, cnt;
    bit rev, fl, match, acc, rel_ok, exp_succ;
    #1;
    for (int i = 0; i < NA; i++) cur[i] = m_map[m_work][i];
    for (int j = 0; j < W; j++) begin
      for (int k = 0; k < 2; k++)
        chk($sformatf("src_phys[%0d][%0d]", j, k), 32'(src_phys_tag[j][k]), cur[src_arch_tag[j][k]]);
      chk($sformatf("old_phys[%0d]", j), 32'(rename_old_phys_tag[j]), cur[rename_dest_arch_tag[j]]);
      if (rename_valid[j]) cur[rename_dest_arch_tag[j]] = rename_dest_phys_tag[j];
    end
    w1    = (m_work + 1) % C;
    rc    = restore_column;
    idx   = save_checkpoint_ROB_index;
    rarch = revert_dest_arch_tag;
    rsafe = revert_safe_phys_tag;
    rev   = revert_valid;
    fl    = restore_valid && restore_speculate_failed;
    match = m_valid[rc] && (m_rob[rc] == restore_ROB_index);
    acc   = save_checkpoint_valid && !rev && !fl && !m_valid[w1];
    rel_ok = restore_valid && !restore_speculate_failed && match && (rc != m_work);
    exp_succ = fl ? (!rev && match) : rel_ok;
    cnt = 0;
    for (int c = 0; c < C; c++) cnt += m_valid[c];
    chk("accepted", 32'(save_checkpoint_accepted), 32'(acc));
    chk("success", 32'(restore_success), 32'(exp_succ));
    chk("save_column", 32'(save_checkpoint_column), m_work);
    chk("full", 32'(checkpoint_full), 32'(m_valid[w1]));
    chk("in_use", 32'(checkpoints_in_use), cnt);
    @(posedge CLK);
    if (rev) begin
      m_map[m_work][rarch] = rsafe;
      for (int c = 0; c < C; c++) if (c != m_work) m_valid[c] = 0;
    end else if (fl) begin
      if (match) begin
        m_work = rc;
        for (int c = 0; c < C; c++) if (c != rc) m_valid[c] = 0;
      end
    end else begin
      for (int i = 0; i < NA; i++) m_map[m_work][i] = cur[i];
      if (acc) begin
        for (int i = 0; i < NA; i++) m_map[w1][i] = cur[i];
        m_valid[w1] = 1; m_rob[w1] = idx; m_rob[m_work] = idx;
        m_work = w1;
      end
    end
    if (rel_ok) m_valid[rc] = 0;
    @(negedge CLK);
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // Identity mapping after reset
    src_arch_tag[0][0] = 5'd5; src_arch_tag[0][1] = 5'd31;
    #1;
    chk("reset_r5", 32'(src_phys_tag[0][0]), 5);
    chk("reset_r31", 32'(src_phys_tag[0][1]), 31);
    chk("reset_in_use", 32'(checkpoints_in_use), 1);
    chk("reset_full", 32'(checkpoint_full), 0);
    step();

    // Two lanes rename r3; lane 1 sees lane 0
    idle();
    rename_valid[0] = 1'b1; rename_dest_arch_tag[0] = 5'd3; rename_dest_phys_tag[0] = 6'd40;
    rename_valid[1] = 1'b1; rename_dest_arch_tag[1] = 5'd3; rename_dest_phys_tag[1] = 6'd41;
    src_arch_tag[1][0] = 5'd3; src_arch_tag[0][0] = 5'd3;
    #1;
    chk("bypass_lane1_src", 32'(src_phys_tag[1][0]), 40);
    chk("no_bypass_lane0_src", 32'(src_phys_tag[0][0]), 3);
    chk("old_lane0", 32'(rename_old_phys_tag[0]), 3);
    chk("old_lane1", 32'(rename_old_phys_tag[1]), 40);
    step();
    idle();
    src_arch_tag[0][0] = 5'd3;
    #1;
    chk("r3_after", 32'(src_phys_tag[0][0]), 41);
    step();

    // Save ROB 7 with a same-cycle rename
    idle();
    save_checkpoint_valid = 1'b1; save_checkpoint_ROB_index = 6'd7;
    rename_valid[0] = 1'b1; rename_dest_arch_tag[0] = 5'd4; rename_dest_phys_tag[0] = 6'd50;
    #1;
    chk("save_col0", 32'(save_checkpoint_column), 0);
    chk("save_acc", 32'(save_checkpoint_accepted), 1);
    step();
    idle();
    src_arch_tag[0][0] = 5'd4;
    #1;
    chk("save_col1", 32'(save_checkpoint_column), 1);
    chk("r4_working", 32'(src_phys_tag[0][0]), 50);
    step();

    // Rename r2, then mispredict back to col0
    idle();
    rename_valid[0] = 1'b1; rename_dest_arch_tag[0] = 5'd2; rename_dest_phys_tag[0] = 6'd60;
    step();
    idle();
    restore_valid = 1'b1; restore_speculate_failed = 1'b1;
    restore_column = 2'd0; restore_ROB_index = 6'd7;
    #1;
    chk("restore_ok", 32'(restore_success), 1);
    step();
    idle();
    src_arch_tag[0][0] = 5'd2; src_arch_tag[0][1] = 5'd4;
    #1;
    chk("restored_r2", 32'(src_phys_tag[0][0]), 2);
    chk("restored_r4", 32'(src_phys_tag[0][1]), 50);
    chk("restored_in_use", 32'(checkpoints_in_use), 1);
    chk("restored_work", 32'(save_checkpoint_column), 0);
    step();

    // Wrong tag
    idle();
    restore_valid = 1'b1; restore_speculate_failed = 1'b1;
    restore_column = 2'd0; restore_ROB_index = 6'd8;
    #1;
    chk("wrong_tag", 32'(restore_success), 0);
    step();
    idle();
    src_arch_tag[0][0] = 5'd4;
    #1;
    chk("wrong_tag_map", 32'(src_phys_tag[0][0]), 50);
    chk("wrong_tag_work", 32'(save_checkpoint_column), 0);
    step();

    // Fill the ring, then release col 1
    for (int s = 0; s < 3; s++) begin
      idle();
      save_checkpoint_valid = 1'b1; save_checkpoint_ROB_index = RW'(10 + s);
      #1;
      chk("fill_acc", 32'(save_checkpoint_accepted), 1);
      step();
    end
    idle();
    save_checkpoint_valid = 1'b1; save_checkpoint_ROB_index = 6'd20;
    #1;
    chk("full_flag", 32'(checkpoint_full), 1);
    chk("full_reject", 32'(save_checkpoint_accepted), 0);
    chk("full_in_use", 32'(checkpoints_in_use), 4);
    step();
    idle();
    restore_valid = 1'b1; restore_speculate_failed = 1'b0;
    restore_column = 2'd1; restore_ROB_index = 6'd11;
    #1;
    chk("release_ok", 32'(restore_success), 1);
    step();
    idle();
    #1;
    chk("release_in_use", 32'(checkpoints_in_use), 3);
    step();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      for (int j = 0; j < W; j++) begin
        src_arch_tag[j][0] = AT'($urandom_range(0, 7));
        src_arch_tag[j][1] = AT'($urandom_range(0, NA - 1));
        rename_valid[j] = ($urandom_range(0, 99) < 60);
        rename_dest_arch_tag[j] = AT'($urandom_range(0, 7));
        rename_dest_phys_tag[j] = PT'($urandom_range(0, NP - 1));
      end
      revert_valid = ($urandom_range(0, 99) < 5);
      revert_dest_arch_tag = AT'($urandom_range(0, 7));
      revert_safe_phys_tag = PT'($urandom_range(0, NP - 1));
      save_checkpoint_valid = ($urandom_range(0, 99) < 30);
      save_checkpoint_ROB_index = RW'($urandom_range(0, 63));
      restore_valid = ($urandom_range(0, 99) < 30);
      restore_speculate_failed = ($urandom_range(0, 99) < 25);
      restore_column = CT'($urandom_range(0, C - 1));
      restore_ROB_index = ($urandom_range(0, 1) == 1) ? RW'(m_rob[restore_column])
                                                      : RW'($urandom_range(0, 63));
      step();
    end

    // Asynchronous reset in mid-cycle
    idle();
    rename_valid[0] = 1'b1; rename_dest_arch_tag[0] = 5'd9; rename_dest_phys_tag[0] = 6'd33;
    save_checkpoint_valid = 1'b1; save_checkpoint_ROB_index = 6'd5;
    step();
    #2;
    nRST = 1'b0;
    #1;
    idle();
    src_arch_tag[0][0] = 5'd9;
    #1;
    chk("async_rst_map", 32'(src_phys_tag[0][0]), 9);
    chk("async_rst_in_use", 32'(checkpoints_in_use), 1);
    chk("async_rst_col", 32'(save_checkpoint_column), 0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    step();
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
